// File: rtl/prog_ctr.sv
// Fetch-stage program counter: IDLE/RUN/DONE sequencer with stall, absolute jump and relative branch.
// Optional 16-bit saturating run-cycle counter enabled by defining PRGCTR_CYCLE_CNT_EN.
module prog_ctr #(
    parameter int D  = 12,
    parameter int OW = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Halt,
    input  logic                 Stall,
    input  logic                 Jump,
    input  logic [D-1:0]         Target,
    input  logic                 BranchRel,
    input  logic signed [OW-1:0] Offset,
    output logic [D-1:0]         PrgCtr,
    output logic                 Running,
    output logic                 Done
`ifdef PRGCTR_CYCLE_CNT_EN
    ,
    output logic [15:0]          CycleCnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [D-1:0] pc_d;

    // Sign-extend the offset to PC width; the add then wraps modulo 2**D in both directions.
    function automatic logic [D-1:0] rel_target(input logic [D-1:0] pc,
                                                input logic signed [OW-1:0] off);
        logic signed [D-1:0] ext;
        ext = off;
        return pc + ext;
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            PrgCtr  <= '0;
        end else begin
            state_q <= state_d;
            PrgCtr  <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = PrgCtr;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) state_d = RUN;
            end
            RUN: begin
                if (Start)          pc_d = '0;
                else if (Halt)      state_d = DONE;
                else if (Stall)     pc_d = PrgCtr;
                else if (Jump)      pc_d = Target;
                else if (BranchRel) pc_d = rel_target(PrgCtr, Offset);
                else                pc_d = PrgCtr + 1'b1;
            end
            DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign Running = (state_q == RUN);
    assign Done    = (state_q == DONE);

`ifdef PRGCTR_CYCLE_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counts every RUN cycle, stalled ones included; freezes in IDLE/DONE for readout.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                CycleCnt <= '0;
        else if (Start)            CycleCnt <= '0;
        else if (state_q == RUN)   CycleCnt <= sat_inc(CycleCnt);
    end
`endif

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: expectations are queued as stimulus is applied and popped after each edge.
module tb_prog_ctr;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic              Halt;
    logic              Stall;
    logic              Jump;
    logic [11:0]       Target;
    logic              BranchRel;
    logic signed [7:0] Offset;
    logic [11:0]       PrgCtr;
    logic              Running;
    logic              Done;
`ifdef PRGCTR_CYCLE_CNT_EN
    logic [15:0]       CycleCnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        st;
        logic        hl;
        logic        sl;
        logic        jp;
        logic [11:0] tg;
        logic        br;
        logic [7:0]  off;
    } stim_t;

    typedef struct {
        logic [11:0] pc;
        logic        run;
        logic        done;
    } exp_t;

    exp_t sb[$];

    prog_ctr #(.D(12), .OW(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Halt      (Halt),
        .Stall     (Stall),
        .Jump      (Jump),
        .Target    (Target),
        .BranchRel (BranchRel),
        .Offset    (Offset),
        .PrgCtr    (PrgCtr),
        .Running   (Running),
        .Done      (Done)
`ifdef PRGCTR_CYCLE_CNT_EN
        ,
        .CycleCnt  (CycleCnt)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(input logic st, input logic hl, input logic sl, input logic jp,
                                 input logic [11:0] tg, input logic br, input logic [7:0] off);
        stim_t s;
        s.st = st; s.hl = hl; s.sl = sl; s.jp = jp; s.tg = tg; s.br = br; s.off = off;
        return s;
    endfunction

    function automatic stim_t idle_s();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00);
    endfunction

    function automatic exp_t ex(input logic [11:0] pc, input logic run, input logic done);
        exp_t e;
        e.pc = pc; e.run = run; e.done = done;
        return e;
    endfunction

    // Apply one cycle of stimulus, queue its expected outcome, then step past the edge.
    task automatic drive(input stim_t s, input exp_t e);
        Start = s.st; Halt = s.hl; Stall = s.sl; Jump = s.jp;
        Target = s.tg; BranchRel = s.br; Offset = s.off;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        Reset = 1'b0;
        Start = 1'b0; Halt = 1'b0; Stall = 1'b0; Jump = 1'b0;
        Target = '0; BranchRel = 1'b0; Offset = '0;
        #2;
        sb.push_back(ex(12'h000, 1'b0, 1'b0));
        x = sb.pop_front();
        tests_run++;
        if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
            tests_failed++;
            $display("FAIL reset_init: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                     PrgCtr, Running, Done, x.pc, x.run, x.done);
        end
        drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00), ex(12'h000, 1'b0, 1'b0));
        x = sb.pop_front();
        tests_run++;
        if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
            tests_failed++;
            $display("FAIL reset_hold_start: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                     PrgCtr, Running, Done, x.pc, x.run, x.done);
        end
        Start = 1'b0;
        #2 Reset = 1'b1;
        @(posedge Clk); #1;

        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h05A, 1'b0, 8'h00)); e.push_back(ex(12'h05A, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            x = sb.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
                tests_failed++;
                $display("FAIL reset_prerun[%0d]: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                         i, PrgCtr, Running, Done, x.pc, x.run, x.done);
            end
        end

        // Mid-cycle asynchronous assertion: outputs must clear without a clock edge.
        Jump = 1'b0;
        #2 Reset = 1'b0;
        sb.push_back(ex(12'h000, 1'b0, 1'b0));
        #1;
        x = sb.pop_front();
        tests_run++;
        if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
            tests_failed++;
            $display("FAIL reset_async: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                     PrgCtr, Running, Done, x.pc, x.run, x.done);
        end
        #3 Reset = 1'b1;
        @(posedge Clk); #1;

        s.delete(); e.delete();
        s.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 12'h077, 1'b1, 8'h04)); e.push_back(ex(12'h000, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h001, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h002, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h003, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            x = sb.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
                tests_failed++;
                $display("FAIL reset_restart[%0d]: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                         i, PrgCtr, Running, Done, x.pc, x.run, x.done);
            end
        end
    endtask

    task automatic test_jump_priority();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h010, 1'b0, 8'h00)); e.push_back(ex(12'h010, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b1, 8'h05)); e.push_back(ex(12'h123, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h124, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            x = sb.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
                tests_failed++;
                $display("FAIL jump_priority[%0d]: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                         i, PrgCtr, Running, Done, x.pc, x.run, x.done);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h002, 1'b0, 8'h00)); e.push_back(ex(12'h002, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'hFB)); e.push_back(ex(12'hFFD, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 1'b0, 8'h00)); e.push_back(ex(12'hFFF, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h000, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'hFF)); e.push_back(ex(12'hFFF, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h000, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            x = sb.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                         i, PrgCtr, Running, Done, x.pc, x.run, x.done);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h020, 1'b0, 8'h00)); e.push_back(ex(12'h020, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h020, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h300, 1'b0, 8'h00)); e.push_back(ex(12'h020, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h020, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h021, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 8'h10)); e.push_back(ex(12'h021, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h022, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            x = sb.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                         i, PrgCtr, Running, Done, x.pc, x.run, x.done);
            end
        end
    endtask

    task automatic test_halt();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h030, 1'b0, 8'h00)); e.push_back(ex(12'h030, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 12'h100, 1'b0, 8'h00)); e.push_back(ex(12'h030, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 12'h200, 1'b1, 8'h10)); e.push_back(ex(12'h030, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h030, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h3FF, 1'b0, 8'h00)); e.push_back(ex(12'h030, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'h05)); e.push_back(ex(12'h030, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h030, 1'b0, 1'b1));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h001, 1'b1, 1'b0));
        s.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 12'h555, 1'b0, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'h001, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            x = sb.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
                tests_failed++;
                $display("FAIL halt[%0d]: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                         i, PrgCtr, Running, Done, x.pc, x.run, x.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'h03)); e.push_back(ex(12'h004, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'hFE)); e.push_back(ex(12'h002, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'hABC, 1'b0, 8'h00)); e.push_back(ex(12'hABC, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'h7F)); e.push_back(ex(12'hB3B, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'h80)); e.push_back(ex(12'hABB, 1'b1, 1'b0));
        s.push_back(idle_s()); e.push_back(ex(12'hABC, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            x = sb.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got pc=%h run=%b done=%b, required pc=%h run=%b done=%b",
                         i, PrgCtr, Running, Done, x.pc, x.run, x.done);
            end
        end
    endtask

`ifdef PRGCTR_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        stim_t       s[$];
        exp_t        e[$];
        logic [15:0] c[$];
        logic [15:0] cq[$];
        exp_t        x;
        logic [15:0] xc;
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0)); c.push_back(16'd0);
        s.push_back(idle_s()); e.push_back(ex(12'h001, 1'b1, 1'b0)); c.push_back(16'd1);
        s.push_back(idle_s()); e.push_back(ex(12'h002, 1'b1, 1'b0)); c.push_back(16'd2);
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h002, 1'b1, 1'b0)); c.push_back(16'd3);
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h002, 1'b1, 1'b0)); c.push_back(16'd4);
        for (int k = 0; k < 6; k++) begin
            s.push_back(idle_s()); e.push_back(ex(12'(3 + k), 1'b1, 1'b0)); c.push_back(16'(5 + k));
        end
        s.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h008, 1'b0, 1'b1)); c.push_back(16'd11);
        s.push_back(idle_s()); e.push_back(ex(12'h008, 1'b0, 1'b1)); c.push_back(16'd11);
        s.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h040, 1'b0, 8'h00)); e.push_back(ex(12'h008, 1'b0, 1'b1)); c.push_back(16'd11);
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00)); e.push_back(ex(12'h000, 1'b1, 1'b0)); c.push_back(16'd0);
        foreach (s[i]) begin
            cq.push_back(c[i]);
            drive(s[i], e[i]);
            x  = sb.pop_front();
            xc = cq.pop_front();
            tests_run++;
            if (PrgCtr !== x.pc || Running !== x.run || Done !== x.done || CycleCnt !== xc) begin
                tests_failed++;
                $display("FAIL cycle_cnt[%0d]: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                         i, PrgCtr, Running, Done, CycleCnt, x.pc, x.run, x.done, xc);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_jump_priority();
        test_wrap();
        test_stall();
        test_halt();
        test_back_to_back();
`ifdef PRGCTR_CYCLE_CNT_EN
        test_cycle_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prog_ctr.md
Name: prog_ctr

Overview:
- Fetch-stage program counter that drives the instruction ROM address input.
- Sequences execution from a start pulse to a halt, stepping by one or redirecting on an absolute jump or a PC-relative branch from the decoder/ALU.
- Supports stall holds and reports run/done status to the top level and test bench.

Parameters:
D, 12, program counter width; addressable program depth 2**D words (matches ROM address width)
OW, 8, width of signed relative branch offset

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Start  input  1  level-sampled start/restart request
Halt  input  1  decoded halt instruction at current PrgCtr
Stall  input  1  hold PrgCtr this cycle (multi-cycle op in flight)
Jump  input  1  absolute jump taken
Target  input  D  absolute jump destination
BranchRel  input  1  relative branch taken
Offset  input  OW  signed two's-complement branch offset
PrgCtr  output  D  registered instruction address to ROM
Running  output  1  1 while in RUN state
Done  output  1  1 while in DONE state

Behaviour:
- Reset asserted (low) → immediately, independent of Clk:
  - PrgCtr=0, state=IDLE, Running=0, Done=0.
  - Applies mid-run; all in-flight redirects are lost.
- Reset deasserts asynchronously; the first update is on the next rising Clk with Reset=1.
- All outputs are registered or decoded purely from the state register; no combinational input-to-output path. Latency from any control input to PrgCtr is 1 cycle.
- States: IDLE, RUN, DONE. Running=(state==RUN); Done=(state==DONE).
- IDLE:
  - PrgCtr holds 0.
  - Start=1 → RUN, PrgCtr<=0. Otherwise remain in IDLE.
  - All other inputs ignored.
- RUN, per-edge priority (highest first):
  1. Start=1 → PrgCtr<=0, stay RUN (restart).
  2. Halt=1 → DONE, PrgCtr holds (points at halt instruction).
  3. Stall=1 → PrgCtr holds.
  4. Jump=1 → PrgCtr<=Target.
  5. BranchRel=1 → PrgCtr<=PrgCtr + sign_extend(Offset), truncated to D bits (mod 2**D).
  6. else → PrgCtr<=PrgCtr+1, mod 2**D.
- Arithmetic rules:
  - Sequential increment wraps 2**D-1 → 0; no error flag.
  - Relative arithmetic wraps in both directions: 0 + (-1) = 2**D-1.
  - Offset=0 with BranchRel → PrgCtr unchanged (self-loop); legal.
- Simultaneous events:
  - Jump and BranchRel both high → Jump wins.
  - Halt with Stall, Jump or BranchRel → Halt wins; no redirect applied.
  - Stall with Jump/BranchRel → redirect dropped; the decoder must re-assert it once the stall clears.
- DONE:
  - PrgCtr holds; Done=1 every cycle.
  - Start=1 → RUN, PrgCtr<=0, Done=0 from the next cycle.
  - Halt, Stall, Jump, BranchRel ignored.
- Start held high continuously in RUN keeps PrgCtr at 0 (repeated restart). The bench or top level must pulse Start for one cycle.
- No X propagation: unknown Target/Offset are sampled only when the corresponding take bit is 1.

Optional Feature:
- Macro: PRGCTR_CYCLE_CNT_EN.
- Defined:
  - Adds output CycleCnt, 16 bits.
  - Cleared to 0 on Reset and on every accepted Start.
  - Increments by 1 each cycle in RUN, including stalled cycles; saturates at 16'hFFFF.
  - Holds in IDLE and DONE, giving total execution cycles at Done.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
- Reset low mid-run with PrgCtr=0x05A, then high; Start pulse → PrgCtr=0 instantly on Reset; Running=1 one edge after Start; PrgCtr 0,1,2,3 on consecutive edges.
- RUN at PrgCtr=0x010, Jump=1, Target=0x123 and BranchRel=1, Offset=0x05 same cycle → next PrgCtr=0x123 (Jump priority), then 0x124.
- RUN at PrgCtr=0x002, BranchRel=1, Offset=0xFB (-5) → PrgCtr=0xFFD (wrap); at PrgCtr=0xFFF with no redirect → 0x000.
- RUN at PrgCtr=0x020, Stall=1 for 3 cycles with Jump=1 on the 2nd → PrgCtr=0x020 for 3 edges, then 0x021 (jump dropped).
- PrgCtr=0x030, Halt=1 and Jump=1 → DONE, PrgCtr stays 0x030, Done=1; inputs toggled for 5 cycles → no change. Start pulse → PrgCtr=0, Done=0, Running=1.
- With PRGCTR_CYCLE_CNT_EN: Start, 10 run cycles including 2 stalls, then Halt → CycleCnt=11 held in DONE; new Start clears it to 0.
